// File: rtl/spike_fifo_pkg.sv
// Shared types and helpers for the spike event FIFO: default field widths,
// the packed event record and a width helper for occupancy counters.
package spike_fifo_pkg;

    localparam int unsigned BT_WIDTH_DEF     = 36;
    localparam int unsigned NEURON_WIDTH_DEF = 11;

    typedef struct packed {
        logic [BT_WIDTH_DEF-1:0]     bt;
        logic [NEURON_WIDTH_DEF-1:0] nid;
    } spike_event_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spike_fifo_mem.sv
// Event storage for the spike FIFO: synchronous write port, asynchronous read
// port so the head entry can be peeked combinationally.
module spike_fifo_mem #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 47
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spike_event_fifo.sv
// Circular FIFO of (biological-time, neuron-ID) spike events with simultaneous
// push/pop, flush, occupancy count, almost-full and sticky error flags.
module spike_event_fifo
    import spike_fifo_pkg::*;
#(
    parameter  int unsigned BT_WIDTH           = BT_WIDTH_DEF,
    parameter  int unsigned NEURON_WIDTH       = NEURON_WIDTH_DEF,
    parameter  int unsigned DEPTH_LOG2         = 4,
    parameter  int unsigned ALMOST_FULL_THRESH = 2**DEPTH_LOG2 - 2,
    localparam int unsigned COUNT_W            = clog2(2**DEPTH_LOG2 + 1)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    QueueEnable,
    input  logic                    Enqueue,
    input  logic                    Dequeue,
    input  logic                    Flush,
    input  logic                    ClearErr,
    input  logic [BT_WIDTH-1:0]     BTIn,
    input  logic [NEURON_WIDTH-1:0] NIDIn,
    output logic [BT_WIDTH-1:0]     BTOut,
    output logic [NEURON_WIDTH-1:0] NIDOut,
    output logic                    OutValid,
    output logic [BT_WIDTH-1:0]     BT_Head,
    output logic [NEURON_WIDTH-1:0] NID_Head,
    output logic [COUNT_W-1:0]      Count,
    output logic                    IsQueueEmpty,
    output logic                    IsQueueFull,
    output logic                    AlmostFull,
    output logic                    Overflow,
    output logic                    Underflow
);

    localparam int unsigned         EW         = BT_WIDTH + NEURON_WIDTH;
    localparam logic [COUNT_W-1:0]  FULL_COUNT = COUNT_W'(2**DEPTH_LOG2);
    localparam logic [COUNT_W-1:0]  AF_COUNT   = COUNT_W'(ALMOST_FULL_THRESH);

    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [EW-1:0]         head;
    logic                  active, do_enq, do_deq, mem_we;
    logic                  ovf_set, unf_set;
    logic [COUNT_W-1:0]    count_next;

    // A push into a full queue is legal when a pop frees the slot on the same edge.
    always_comb begin
        active     = QueueEnable & ~Flush;
        do_enq     = active & Enqueue & (~IsQueueFull | Dequeue);
        do_deq     = active & Dequeue & ~IsQueueEmpty;
        mem_we     = Reset & do_enq;
        ovf_set    = active & Enqueue & IsQueueFull & ~Dequeue;
        unf_set    = active & Dequeue & IsQueueEmpty;
        count_next = Count;
        if (Flush)                count_next = '0;
        else if (do_enq & ~do_deq) count_next = Count + 1'b1;
        else if (~do_enq & do_deq) count_next = Count - 1'b1;
    end

    spike_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (EW)
    ) u_mem (
        .clk     (Clock),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data ({BTIn, NIDIn}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_comb begin
        BT_Head  = '0;
        NID_Head = '0;
        if (!IsQueueEmpty) begin
            BT_Head  = head[EW-1:NEURON_WIDTH];
            NID_Head = head[NEURON_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            Count        <= '0;
            BTOut        <= '0;
            NIDOut       <= '0;
            OutValid     <= 1'b0;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
            IsQueueEmpty <= 1'b1;
            IsQueueFull  <= 1'b0;
            AlmostFull   <= 1'b0;
        end else begin
            // Flags follow count_next so they line up with the registered Count.
            Count        <= count_next;
            IsQueueEmpty <= (count_next == '0);
            IsQueueFull  <= (count_next == FULL_COUNT);
            AlmostFull   <= (count_next >= AF_COUNT);
            OutValid     <= do_deq;
            if (Flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_enq) wr_ptr <= wr_ptr + 1'b1;
                if (do_deq) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    BTOut  <= head[EW-1:NEURON_WIDTH];
                    NIDOut <= head[NEURON_WIDTH-1:0];
                end
                if (active) begin
                    Overflow  <= ovf_set | (Overflow & ~ClearErr);
                    Underflow <= unf_set | (Underflow & ~ClearErr);
                end
            end
        end
    end

endmodule
